// File: rtl/memory_sequencer_if.sv
// Bundle of signals between decode/execute control, the memory sequencer and
// the memory stage. The master side issues ops and interrupt requests; the
// slave side (the sequencer) returns the handshake and drives the strobes.
interface memory_sequencer_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic       int_req;
  logic       op_ready;
  logic       busy;
  logic       done;
  logic       memory_read;
  logic       memory_write;
  logic       memory_push;
  logic       memory_pop;
  logic [1:0] memory_address_select;
  logic [1:0] memory_write_src_select;
  logic       pc_choose_memory;
  logic       interrupt;
  logic       flags_restore;

  modport master (
    output op_valid, op_code, int_req,
    input  op_ready, busy, done,
    input  memory_read, memory_write, memory_push, memory_pop,
    input  memory_address_select, memory_write_src_select,
    input  pc_choose_memory, interrupt, flags_restore
  );

  modport slave (
    input  op_valid, op_code, int_req,
    output op_ready, busy, done,
    output memory_read, memory_write, memory_push, memory_pop,
    output memory_address_select, memory_write_src_select,
    output pc_choose_memory, interrupt, flags_restore
  );
endinterface

// File: rtl/memory_sequencer.sv
// Memory-stage sequencer: expands one decoded memory op, or a pending
// interrupt, into 1-3 single-word memory accesses and stalls upstream with
// busy until the last access. Strobes and selects come straight from flops
// that are loaded with the decode of the next state, so they are glitch-free
// and drop at once on reset.
module memory_sequencer (
  input  logic               clk,
  input  logic               reset,
  memory_sequencer_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Op codes map 1:1 onto the low kinds; the interrupt sequence gets its own.
  typedef enum logic [3:0] {
    K_LDD  = 4'd0,
    K_STD  = 4'd1,
    K_PUSH = 4'd2,
    K_POP  = 4'd3,
    K_CALL = 4'd4,
    K_RET  = 4'd5,
    K_RTI  = 4'd6,
    K_NOP  = 4'd7,
    K_INT  = 4'd8
  } kind_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       read;
    logic       write;
    logic       push;
    logic       pop;
    logic [1:0] addr_sel;
    logic [1:0] src_sel;
    logic       pc_mem;
    logic       intr;
    logic       flags_rst;
  } ctrl_t;

  // Index of the final step of each sequence kind.
  function automatic logic [1:0] last_step(input kind_t k);
    logic [1:0] l;
    case (k)
      K_CALL, K_RET: l = 2'd1;
      K_RTI, K_INT:  l = 2'd2;
      default:       l = 2'd0;
    endcase
    return l;
  endfunction

  // Moore decode of strobes/selects from (state, kind, step).
  function automatic ctrl_t decode_ctrl(input state_t st, input kind_t k, input logic [1:0] step);
    ctrl_t c;
    c = '0;
    if (st == ST_RUN) begin
      c.busy = 1'b1;
      c.done = (step == last_step(k));
      case (k)
        K_LDD: begin
          c.read     = 1'b1;
          c.addr_sel = 2'b01;
        end
        K_STD: begin
          c.write    = 1'b1;
          c.addr_sel = 2'b00;
          c.src_sel  = 2'b11;
        end
        K_PUSH: begin
          c.write    = 1'b1;
          c.push     = 1'b1;
          c.addr_sel = 2'b10;
          c.src_sel  = 2'b11;
        end
        K_POP: begin
          c.read     = 1'b1;
          c.pop      = 1'b1;
          c.addr_sel = 2'b10;
        end
        K_CALL: begin
          // Return address pushed upper half first, then lower half.
          c.write    = 1'b1;
          c.push     = 1'b1;
          c.addr_sel = 2'b10;
          c.src_sel  = (step == 2'd0) ? 2'b01 : 2'b10;
        end
        K_RET, K_RTI: begin
          // PC is reloaded once both halves are popped; RTI pops flags last.
          c.read      = 1'b1;
          c.pop       = 1'b1;
          c.addr_sel  = 2'b10;
          c.pc_mem    = (step == 2'd1);
          c.flags_rst = (k == K_RTI) && (step == 2'd2);
        end
        K_INT: begin
          // Save flags, PC upper, PC lower; vector to 0 on the last push.
          c.write    = 1'b1;
          c.push     = 1'b1;
          c.addr_sel = 2'b10;
          case (step)
            2'd0:    c.src_sel = 2'b00;
            2'd1:    c.src_sel = 2'b01;
            default: begin
              c.src_sel = 2'b10;
              c.intr    = 1'b1;
            end
          endcase
        end
        K_NOP: begin
          c.busy = 1'b1;
        end
        default: begin
          c.busy = 1'b1;
        end
      endcase
    end else begin
      c = '0;
    end
    return c;
  endfunction

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [1:0] step_q, step_d;
  logic       int_pending_q, int_pending_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       op_ready_s;

  // Next-state logic: interrupt beats a same-cycle op; running ops finish.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    step_d        = step_q;
    int_pending_d = int_pending_q | bus.int_req;
    case (state_q)
      ST_IDLE: begin
        step_d = 2'd0;
        if (int_pending_q || bus.int_req) begin
          state_d       = ST_RUN;
          kind_d        = K_INT;
          int_pending_d = 1'b0;
        end else if (bus.op_valid) begin
          state_d = ST_RUN;
          kind_d  = kind_t'({1'b0, bus.op_code});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_q == last_step(kind_q)) begin
          state_d = ST_IDLE;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 2'd0;
      end
    endcase
    ctrl_d = decode_ctrl(state_d, kind_d, step_d);
  end

  // Acceptance handshake: only in IDLE with no interrupt waiting or arriving.
  always_comb begin
    op_ready_s = (state_q == ST_IDLE) && !int_pending_q && !bus.int_req;
  end

  // State, step, pending interrupt and output control flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      kind_q        <= K_NOP;
      step_q        <= 2'd0;
      int_pending_q <= 1'b0;
      ctrl_q        <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      step_q        <= step_d;
      int_pending_q <= int_pending_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign bus.op_ready                = op_ready_s;
  assign bus.busy                    = ctrl_q.busy;
  assign bus.done                    = ctrl_q.done;
  assign bus.memory_read             = ctrl_q.read;
  assign bus.memory_write            = ctrl_q.write;
  assign bus.memory_push             = ctrl_q.push;
  assign bus.memory_pop              = ctrl_q.pop;
  assign bus.memory_address_select   = ctrl_q.addr_sel;
  assign bus.memory_write_src_select = ctrl_q.src_sel;
  assign bus.pc_choose_memory        = ctrl_q.pc_mem;
  assign bus.interrupt               = ctrl_q.intr;
  assign bus.flags_restore           = ctrl_q.flags_rst;

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: table of per-op expected step outputs fed to a
// scoreboard queue, plus hand-written interrupt and reset sequences.
module tb_memory_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  memory_sequencer_if bus ();

  memory_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic       push;
    logic       pop;
    logic [1:0] addr;
    logic [1:0] src;
    logic       pcm;
    logic       intr;
    logic       flr;
  } obs_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] n;
    obs_t       s0;
    obs_t       s1;
    obs_t       s2;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  vec_t vecs[8];
  vec_t int_v;
  obs_t idle_o;

  function automatic obs_t st(input logic done, input logic rd, input logic wr,
                              input logic push, input logic pop,
                              input logic [1:0] addr, input logic [1:0] src,
                              input logic pcm, input logic intr, input logic flr);
    obs_t o;
    o.busy = 1'b1; o.done = done; o.rd = rd; o.wr = wr; o.push = push; o.pop = pop;
    o.addr = addr; o.src = src; o.pcm = pcm; o.intr = intr; o.flr = flr;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [1:0] n,
                               input obs_t s0, input obs_t s1, input obs_t s2);
    vec_t v;
    v.op = op; v.n = n; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  function obs_t sample();
    return {bus.busy, bus.done, bus.memory_read, bus.memory_write, bus.memory_push,
            bus.memory_pop, bus.memory_address_select, bus.memory_write_src_select,
            bus.pc_choose_memory, bus.interrupt, bus.flags_restore};
  endfunction

  task automatic check_obs(input string nm, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,done,rd,wr,push,pop,addr,src,pcm,intr,flr)",
               nm, a, e);
    end
  endtask

  task automatic check_bit(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_q.push_back(v.s0);
    if (v.n > 2'd1) exp_q.push_back(v.s1);
    if (v.n > 2'd2) exp_q.push_back(v.s2);
  endtask

  // Compare one queued expectation per cycle; ends in the cycle of the last one.
  task automatic drain(input string nm, input bit chk_rdy);
    while (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check_obs(nm, e);
      if (chk_rdy) check_bit({nm, " op_ready"}, bus.op_ready, ~e.busy);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.int_req  = 1'b0;
    rst_n        = 1'b0;
    idle_o       = '0;

    vecs[0] = mkv(3'd0, 2'd1, st(1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0), idle_o, idle_o);
    vecs[1] = mkv(3'd1, 2'd1, st(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b11,1'b0,1'b0,1'b0), idle_o, idle_o);
    vecs[2] = mkv(3'd2, 2'd1, st(1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,2'b11,1'b0,1'b0,1'b0), idle_o, idle_o);
    vecs[3] = mkv(3'd3, 2'd1, st(1'b1,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0), idle_o, idle_o);
    vecs[4] = mkv(3'd4, 2'd2, st(1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b01,1'b0,1'b0,1'b0),
                              st(1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,2'b10,1'b0,1'b0,1'b0), idle_o);
    vecs[5] = mkv(3'd5, 2'd2, st(1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0),
                              st(1'b1,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0), idle_o);
    vecs[6] = mkv(3'd6, 2'd3, st(1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0),
                              st(1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0),
                              st(1'b1,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b1));
    vecs[7] = mkv(3'd7, 2'd1, st(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0), idle_o, idle_o);
    int_v   = mkv(3'd0, 2'd3, st(1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0),
                              st(1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b01,1'b0,1'b0,1'b0),
                              st(1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,2'b10,1'b0,1'b1,1'b0));

    // Reset state.
    #12;
    check_obs("reset outputs", idle_o);
    check_bit("reset op_ready", bus.op_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_obs("post-reset idle", idle_o);
    check_bit("post-reset op_ready", bus.op_ready, 1'b1);

    // Every op code through the table.
    for (int i = 0; i < 8; i++) begin
      bus.op_valid = 1'b1;
      bus.op_code  = vecs[i].op;
      #1;
      check_bit($sformatf("op%0d accept op_ready", vecs[i].op), bus.op_ready, 1'b1);
      push_vec(vecs[i]);
      exp_q.push_back(idle_o);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      bus.op_code  = ~vecs[i].op;
      drain($sformatf("op%0d", vecs[i].op), 1'b1);
    end

    // Interrupt wins a same-cycle tie with PUSH; PUSH follows after INT.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd2;
    bus.int_req  = 1'b1;
    #1;
    check_bit("tie op_ready", bus.op_ready, 1'b0);
    push_vec(int_v);
    exp_q.push_back(idle_o);
    @(posedge clk);
    #1;
    bus.int_req = 1'b0;
    drain("tie int", 1'b1);
    push_vec(vecs[2]);
    exp_q.push_back(idle_o);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    drain("push after int", 1'b1);

    // int_req pulse during RET step 0: RET completes, then exactly one INT.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd5;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    check_obs("ret s0", vecs[5].s0);
    bus.int_req = 1'b1;
    @(posedge clk);
    #1;
    bus.int_req = 1'b0;
    check_obs("ret s1", vecs[5].s1);
    check_bit("ret s1 op_ready", bus.op_ready, 1'b0);
    @(posedge clk);
    #1;
    check_obs("ret idle", idle_o);
    check_bit("ret idle op_ready", bus.op_ready, 1'b0);
    push_vec(int_v);
    exp_q.push_back(idle_o);
    @(posedge clk);
    #1;
    drain("int after ret", 1'b0);
    check_bit("int after ret op_ready", bus.op_ready, 1'b1);
    @(posedge clk);
    #1;
    check_obs("no duplicate int", idle_o);

    // Reset asserted in INT step 1.
    bus.int_req = 1'b1;
    @(posedge clk);
    #1;
    bus.int_req = 1'b0;
    check_obs("int s0 pre-reset", int_v.s0);
    @(posedge clk);
    #1;
    check_obs("int s1 pre-reset", int_v.s1);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("reset mid-int async", idle_o);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_obs("held reset no done", idle_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_obs("after mid reset idle", idle_o);
    check_bit("after mid reset op_ready", bus.op_ready, 1'b1);
    @(posedge clk);
    #1;
    check_obs("pending cleared by reset", idle_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
# memory_sequencer

Multi-cycle controller driving the strobes and selects of the memory stage (read/write/push/pop, address select, write-source select, PC-from-memory, interrupt vector). It expands a single decoded memory op or a pending external interrupt into the 1–3 single-word memory accesses required. It holds the upstream pipeline with `busy` until the sequence finishes. It sits between decode/execute control and the memory stage, replacing per-instruction static memory control bits.

## Interface
Parameters: none; all widths are fixed by the memory stage.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  decoded memory op present
- op_code  in  3  000 LDD, 001 STD, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 RTI, 111 NOP
- int_req  in  1  external interrupt request, sampled each cycle
- op_ready  out  1  op accepted on this edge when op_valid & op_ready
- busy  out  1  sequence in progress; upstream stall
- done  out  1  one-cycle pulse in the final step of any sequence
- memory_read, memory_write, memory_push, memory_pop  out  1 each  memory stage strobes
- memory_address_select  out  2  00 std addr, 01 ldd addr, 10 SP
- memory_write_src_select  out  2  00 flags, 01 PC upper, 10 PC lower, 11 register data
- pc_choose_memory  out  1  take PC from memory shift register
- interrupt  out  1  force PC to vector 0
- flags_restore  out  1  latch popped word into flags

## Operation
- States: IDLE, RUN. RUN holds a latched kind (op_code or INT) and a 2-bit step counter (0..2).
- The FSM is Moore. All memory outputs decode from the registered state and step only. In IDLE every strobe and select is 0.
- `int_pending` is set on any cycle with int_req = 1. It clears on the edge an INT sequence starts. An int_req in that same cycle is absorbed and not re-latched.
- IDLE transitions:
  - If int_pending | int_req, go to RUN with kind = INT.
  - Otherwise, if op_valid, go to RUN with kind = op_code.
  - Otherwise, stay in IDLE.
- op_ready = IDLE & ~int_pending & ~int_req. An interrupt always wins a same-cycle tie.
- Step outputs (strobes not listed are 0; select is 00 unless given):
  - LDD: read, addr 01.
  - STD: write, addr 00, src 11.
  - PUSH: write, push, addr 10, src 11.
  - POP: read, pop, addr 10.
  - NOP: no strobes; done only.
  - CALL s0: write, push, addr 10, src 01.
  - CALL s1: write, push, addr 10, src 10.
  - RET s0: read, pop, addr 10.
  - RET s1: read, pop, addr 10, pc_choose_memory.
  - RTI s0/s1: as RET s0/s1.
  - RTI s2: read, pop, addr 10, flags_restore.
  - INT s0: write, push, addr 10, src 00.
  - INT s1: write, push, addr 10, src 01.
  - INT s2: write, push, addr 10, src 10, interrupt.
- Sequence length: 1 step for LDD/STD/PUSH/POP/NOP, 2 for CALL/RET, 3 for RTI/INT. done is asserted in the last step. On the next edge the FSM returns to IDLE and the step counter goes to 0.
- busy = RUN.
- An op is never interrupted. int_req arriving during RUN is latched and serviced from the following IDLE cycle.

## Timing
- Reset (reset = 0), asynchronous: state IDLE, step 0, int_pending 0, all outputs 0 except op_ready. op_ready is 1 once reset = 1 and no int_req is present.
- Reset mid-sequence: strobes drop immediately, the remaining steps are abandoned, and no done is issued.
- Acceptance on edge E0 → step 0 outputs during cycle E0..E1 → step k during cycle Ek..Ek+1.
- Op latency from acceptance to done is N cycles, where N is the step count. The FSM spends one IDLE cycle between sequences, so back-to-back throughput is 1 op per N+1 cycles.
- op_code is sampled only at acceptance; changes during RUN are ignored.
- Strobes are glitch-free per cycle (registered state). The memory stage samples them on the edge closing the step.

## Test plan
- Reset release, then op_valid = 1 with LDD: op_ready = 1. The next cycle shows read = 1, addr = 01, done = 1, busy = 1; IDLE follows with all strobes 0.
- CALL accepted at E0: cycle 1 shows push/write with src 01, cycle 2 shows push/write with src 10 and done. op_ready = 0 during both steps and returns to 1 at cycle 3.
- RTI: three pop/read steps. pc_choose_memory is high only in step 1; flags_restore and done are high only in step 2.
- op_valid (PUSH) and int_req in the same IDLE cycle: INT is taken and op_ready = 0. The interrupt output pulses in step 2. PUSH is accepted in the IDLE cycle after INT's done.
- int_req pulse during RET step 0: RET completes unchanged. The INT sequence starts the edge after returning to IDLE, with no lost or duplicated interrupt.
- reset = 0 asserted in INT step 1: all strobes drop without waiting for a clock. After release the FSM is in IDLE, int_pending = 0, and done was never asserted.
